// File: rtl/ftrace_ras.sv
// Return-address stack fed by the retired jal/jalr event stream: pushes link
// addresses on calls, checks return targets on pops, and exposes top-of-stack.
module ftrace_ras #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dpi_valid,
  input  logic             func_flag,
  input  logic             is_ret,
  input  logic             is_rd0,
  input  logic [31:0]      pc,
  input  logic [31:0]      nextpc,
  input  logic             flush,
  output logic             top_valid,
  output logic [31:0]      top_addr,
  output logic [PTR_W:0]   depth,
  output logic             ret_hit,
  output logic             ret_miss,
  output logic             overflow,
  output logic             underflow,
  output logic [15:0]      miss_cnt
);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   cnt;

  logic             is_call;
  logic             is_pop;
  logic [PTR_W-1:0] ptr_m1;
  logic [PTR_W-1:0] ptr_m2;
  logic [31:0]      link;
  logic             stack_full;
  logic             stack_empty;
  logic             target_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Event decode and pointer arithmetic from registered state.
  always_comb begin
    is_call     = dpi_valid & func_flag & ~is_ret & ~is_rd0;
    is_pop      = dpi_valid & func_flag & is_ret;
    ptr_m1      = ptr - PTR_W'(1);
    ptr_m2      = ptr - PTR_W'(2);
    link        = pc + 32'd4;
    stack_full  = (cnt == (PTR_W+1)'(DEPTH));
    stack_empty = (cnt == (PTR_W+1)'(0));
    target_hit  = (nextpc == mem[ptr_m1]);
  end

  // Stack storage: a full stack simply overwrites its oldest slot.
  always_ff @(posedge clock) begin
    if (!reset && !flush && is_call) begin
      mem[ptr] <= link;
    end
  end

  // Pointer, count, pulses, miss counter and the registered top-of-stack.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      cnt       <= '0;
      miss_cnt  <= 16'h0000;
      ret_hit   <= 1'b0;
      ret_miss  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      top_valid <= 1'b0;
      top_addr  <= 32'h0000_0000;
    end else begin
      ret_hit   <= 1'b0;
      ret_miss  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (flush) begin
        ptr       <= '0;
        cnt       <= '0;
        top_valid <= 1'b0;
        top_addr  <= 32'h0000_0000;
      end else if (is_call) begin
        ptr       <= ptr + PTR_W'(1);
        top_valid <= 1'b1;
        top_addr  <= link;
        if (stack_full) begin
          overflow <= 1'b1;
        end else begin
          cnt <= cnt + (PTR_W+1)'(1);
        end
      end else if (is_pop) begin
        if (stack_empty) begin
          underflow <= 1'b1;
          miss_cnt  <= sat_inc(miss_cnt);
        end else begin
          if (target_hit) begin
            ret_hit <= 1'b1;
          end else begin
            ret_miss <= 1'b1;
            miss_cnt <= sat_inc(miss_cnt);
          end
          ptr <= ptr_m1;
          cnt <= cnt - (PTR_W+1)'(1);
          // The entry below the popped one becomes the new top.
          if (cnt == (PTR_W+1)'(1)) begin
            top_valid <= 1'b0;
            top_addr  <= 32'h0000_0000;
          end else begin
            top_valid <= 1'b1;
            top_addr  <= mem[ptr_m2];
          end
        end
      end
    end
  end

  assign depth = cnt;

endmodule

// File: tb/tb_ftrace_ras.sv
// Self-checking bench for ftrace_ras: directed scenarios plus random traffic,
// compared every cycle against a queue-based return-stack model.
module tb_ftrace_ras;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset;
  logic             dpi_valid;
  logic             func_flag;
  logic             is_ret;
  logic             is_rd0;
  logic [31:0]      pc;
  logic [31:0]      nextpc;
  logic             flush;
  logic             top_valid;
  logic [31:0]      top_addr;
  logic [PTR_W:0]   depth;
  logic             ret_hit;
  logic             ret_miss;
  logic             overflow;
  logic             underflow;
  logic [15:0]      miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: newest entry at the back of the queue.
  logic [31:0] stk[$];
  int          m_miss = 0;

  ftrace_ras #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .dpi_valid(dpi_valid), .func_flag(func_flag),
    .is_ret(is_ret), .is_rd0(is_rd0), .pc(pc), .nextpc(nextpc), .flush(flush),
    .top_valid(top_valid), .top_addr(top_addr), .depth(depth),
    .ret_hit(ret_hit), .ret_miss(ret_miss), .overflow(overflow),
    .underflow(underflow), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare every output.
  task automatic step(input logic r, input logic fl, input logic v, input logic ff,
                      input logic rt, input logic rd0, input logic [31:0] p,
                      input logic [31:0] np);
    logic e_hit, e_miss, e_ovf, e_unf;
    logic [31:0] t;
    reset = r; flush = fl; dpi_valid = v; func_flag = ff;
    is_ret = rt; is_rd0 = rd0; pc = p; nextpc = np;
    @(posedge clock);
    #1;
    e_hit = 1'b0; e_miss = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    if (r) begin
      stk.delete();
      m_miss = 0;
    end else if (fl) begin
      stk.delete();
    end else if (v && ff) begin
      if (rt) begin
        if (stk.size() == 0) begin
          e_unf = 1'b1;
          if (m_miss < 65535) m_miss++;
        end else begin
          t = stk.pop_back();
          if (t == np) e_hit = 1'b1;
          else begin
            e_miss = 1'b1;
            if (m_miss < 65535) m_miss++;
          end
        end
      end else if (!rd0) begin
        stk.push_back(p + 32'd4);
        if (stk.size() > DEPTH) begin
          void'(stk.pop_front());
          e_ovf = 1'b1;
        end
      end
    end
    check_val("depth",     32'(depth),     32'(stk.size()));
    check_val("top_valid", 32'(top_valid), 32'(stk.size() != 0));
    check_val("top_addr",  top_addr,       (stk.size() != 0) ? stk[$] : 32'h0);
    check_val("ret_hit",   32'(ret_hit),   32'(e_hit));
    check_val("ret_miss",  32'(ret_miss),  32'(e_miss));
    check_val("overflow",  32'(overflow),  32'(e_ovf));
    check_val("underflow", 32'(underflow), 32'(e_unf));
    check_val("miss_cnt",  32'(miss_cnt),  32'(m_miss));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask
  task automatic do_call(input logic [31:0] p);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, p, p + 32'h100);
  endtask
  task automatic do_ret(input logic [31:0] np);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0400, np);
  endtask

  initial begin
    logic [31:0] rp, rn;
    int sel;
    reset = 1'b1; flush = 1'b0; dpi_valid = 1'b0; func_flag = 1'b0;
    is_ret = 1'b0; is_rd0 = 1'b0; pc = 32'h0; nextpc = 32'h0;
    do_reset();
    do_reset();

    // Push/pop match.
    do_call(32'h8000_0010);
    do_call(32'h8000_0100);
    do_ret(32'h8000_0104);
    do_ret(32'h8000_0014);

    // Mismatch.
    do_call(32'h8000_0000);
    do_ret(32'h8000_0008);

    // Overflow then underflow.
    do_reset();
    for (int i = 0; i < 17; i++) do_call(32'h1000 + 32'(16 * i));
    for (int i = 0; i < 16; i++) do_ret(32'h1104 - 32'(16 * i));
    do_ret(32'h1004);
    check_val("ovf_unf_miss_cnt", 32'(miss_cnt), 32'd1);

    // Jump filtering: tail call, non-function event, invalid event.
    do_call(32'h2000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2100, 32'h3000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2200, 32'h1234);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2300, 32'h2004);
    do_ret(32'h2004);

    // Flush beats a same-cycle return; reset clears everything.
    for (int i = 0; i < 3; i++) do_call(32'h4000 + 32'(8 * i));
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h4014);
    do_call(32'h5000);
    do_call(32'h5010);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h6000, 32'h0);
    check_val("post_reset_top", top_addr, 32'h0);

    // Wrap of link address.
    do_call(32'hFFFF_FFFC);
    check_val("wrap_top", top_addr, 32'h0);
    do_ret(32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      rp  = {$urandom_range(0, 255) == 0 ? 30'h3FFF_FFFF : 30'($urandom), 2'b00};
      rn  = (stk.size() != 0 && $urandom_range(0, 3) != 0) ? stk[$] : $urandom;
      if (sel < 40)      do_call(rp);
      else if (sel < 75) do_ret(rn);
      else if (sel < 85) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rp, rn);
      else if (sel < 95) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                              1'($urandom), rp, rn);
      else if (sel < 98) step(1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom), 1'b0, rp, rn);
      else               step(1'b1, 1'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, rp, rn);
    end

    // Miss counter saturation.
    do_reset();
    for (int i = 0; i < 65538; i++) do_ret(32'h0);
    check_val("miss_sat", 32'(miss_cnt), 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
